mouse_packet_decoder: RTL

Assembles the PS/2 mouse byte stream into 3-byte movement packets and converts them into the speed/direction/button signals consumed by `objectMouseMove`. Sits between the PS/2 byte receiver (`ready` level + `data[7:0]`) and the mouse cursor motion block. It replaces ad-hoc packet capture logic in the top level. It edge-detects the receiver's ready level, resynchronises on bad framing or inter-byte timeout, and holds each velocity for exactly one move period.

---
 rtl/mouse_packet_decoder_if.sv | 30 +++
 rtl/mouse_packet_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mouse_packet_decoder_if.sv
// Bus between the PS/2 byte receiver / motion clock and the packet decoder.
interface mouse_packet_decoder_if;
  logic       ps2_ready;
  logic [7:0] ps2_data;
  logic       move_tick;
  logic [9:0] vx;
  logic [9:0] vy;
  logic       dx;
  logic       dy;
  logic       btn_left;
  logic       btn_right;
  logic       btn_middle;
  logic       left_press;
  logic       packet_valid;
  logic       sync_err;

  // Source side: receiver bytes and motion clock in, decoded motion out.
  modport master (
    output ps2_ready, ps2_data, move_tick,
    input  vx, vy, dx, dy, btn_left, btn_right, btn_middle,
           left_press, packet_valid, sync_err
  );

  // Decoder side.
  modport slave (
    input  ps2_ready, ps2_data, move_tick,
    output vx, vy, dx, dy, btn_left, btn_right, btn_middle,
           left_press, packet_valid, sync_err
  );
endinterface

// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte packets into per-axis speed,
// direction and button levels, holding velocity for one move period.
// Optional feature: MOUSE_SYNC_CHECK_EN rejects byte 0 when its sync bit is 0.
module mouse_packet_decoder #(
  parameter int unsigned TIMEOUT = 5_000_000,
  parameter int unsigned SHIFT   = 1
) (
  input logic              clk,
  input logic              rst,
  mouse_packet_decoder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {B0, B1, B2} pkt_state_t;
  typedef enum logic [1:0] {IDLE, ARMED, WAIT_FALL} hold_state_t;

  pkt_state_t  pkt_state, pkt_next;
  hold_state_t hold_state, hold_next;

  logic [1:0]       ready_sr;
  logic [1:0]       tick_sr;
  logic [CNT_W-1:0] tmo_cnt;
  logic [2:0]       btn_q;
  logic [3:0]       flag_q;
  logic [7:0]       x_q;

  logic byte_rise, tick_rise, tick_fall;
  logic timeout_c, sync_ok_c;
  logic cap_b0_c, cap_x_c, done_c, drop_c, clear_c;

  // Axis magnitude of a 9-bit sign/magnitude-by-two's-complement value.
  function automatic logic [9:0] axis_mag(input logic sign, input logic ovf,
                                          input logic [7:0] val);
    logic [9:0] ext;
    logic [9:0] mag;
    ext = {sign, sign, val};
    if (ovf)       mag = 10'd255;
    else if (sign) mag = 10'(10'd0 - ext);
    else           mag = ext;
    return mag >> SHIFT;
  endfunction

  assign byte_rise = (ready_sr == 2'b01);
  assign tick_rise = (tick_sr == 2'b01);
  assign tick_fall = (tick_sr == 2'b10);
  assign timeout_c = (pkt_state != B0) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

`ifdef MOUSE_SYNC_CHECK_EN
  assign sync_ok_c = bus.ps2_data[3];
`else
  assign sync_ok_c = 1'b1;
`endif

  // Edge samplers for the receiver ready level and the motion clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_sr <= 2'b00;
      tick_sr  <= 2'b00;
    end else begin
      ready_sr <= {ready_sr[0], bus.ps2_ready};
      tick_sr  <= {tick_sr[0], bus.move_tick};
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk) begin
    if (rst) pkt_state <= B0;
    else     pkt_state <= pkt_next;
  end

  // Packet FSM next state; an arriving byte beats a simultaneous timeout.
  always_comb begin
    pkt_next = pkt_state;
    case (pkt_state)
      B0: if (byte_rise && sync_ok_c) pkt_next = B1;
      B1: begin
        if (byte_rise)      pkt_next = B2;
        else if (timeout_c) pkt_next = B0;
      end
      B2: begin
        if (byte_rise)      pkt_next = B0;
        else if (timeout_c) pkt_next = B0;
      end
      default: pkt_next = B0;
    endcase
  end

  // Packet FSM strobes.
  always_comb begin
    cap_b0_c = 1'b0;
    cap_x_c  = 1'b0;
    done_c   = 1'b0;
    drop_c   = 1'b0;
    case (pkt_state)
      B0: begin
        cap_b0_c = byte_rise && sync_ok_c;
        drop_c   = byte_rise && !sync_ok_c;
      end
      B1:      cap_x_c = byte_rise;
      B2:      done_c  = byte_rise;
      default: ;
    endcase
  end

  // Inter-byte timeout counter, idle while waiting for byte 0.
  always_ff @(posedge clk) begin
    if (rst || pkt_state == B0 || byte_rise) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  // Partial packet capture (byte 0 fields and X).
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q  <= '0;
      flag_q <= '0;
      x_q    <= '0;
    end else begin
      if (cap_b0_c) begin
        btn_q  <= bus.ps2_data[2:0];
        flag_q <= bus.ps2_data[7:4];
      end
      if (cap_x_c) x_q <= bus.ps2_data;
    end
  end

  // Hold FSM state register.
  always_ff @(posedge clk) begin
    if (rst) hold_state <= IDLE;
    else     hold_state <= hold_next;
  end

  // Hold FSM next state; a new packet always restarts at ARMED.
  always_comb begin
    hold_next = hold_state;
    if (done_c) hold_next = ARMED;
    else begin
      case (hold_state)
        ARMED:     if (tick_rise) hold_next = WAIT_FALL;
        WAIT_FALL: if (tick_fall) hold_next = IDLE;
        default:   hold_next = hold_state;
      endcase
    end
  end

  // Hold FSM output: velocity clear at the end of the move period.
  always_comb begin
    clear_c = 1'b0;
    if (hold_state == WAIT_FALL && tick_fall && !done_c) clear_c = 1'b1;
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vx           <= '0;
      bus.vy           <= '0;
      bus.dx           <= 1'b0;
      bus.dy           <= 1'b0;
      bus.btn_left     <= 1'b0;
      bus.btn_right    <= 1'b0;
      bus.btn_middle   <= 1'b0;
      bus.left_press   <= 1'b0;
      bus.packet_valid <= 1'b0;
      bus.sync_err     <= 1'b0;
    end else begin
      bus.packet_valid <= done_c;
      bus.left_press   <= done_c && btn_q[0] && !bus.btn_left;
      bus.sync_err     <= drop_c;
      if (done_c) begin
        bus.vx         <= axis_mag(flag_q[0], flag_q[2], x_q);
        bus.vy         <= axis_mag(flag_q[1], flag_q[3], bus.ps2_data);
        bus.dx         <= !flag_q[0];
        bus.dy         <= !flag_q[1];
        bus.btn_left   <= btn_q[0];
        bus.btn_right  <= btn_q[1];
        bus.btn_middle <= btn_q[2];
      end else if (clear_c) begin
        bus.vx <= '0;
        bus.vy <= '0;
      end
    end
  end

endmodule
